// File: rtl/regfile_wb_sched.sv
// rtl/regfile_wb_sched.sv - two-requester register write-back scheduler with WAW blocking and pending scoreboard
module regfile_wb_sched #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        regWrite,
  output logic [4:0]  writeReg,
  output logic [31:0] writeData,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  output logic        stall,
  output logic [31:0] pending,
  output logic        idle
);
  localparam int AW = $clog2(DEPTH);

  // index 0 is requester A, index 1 is requester B
  logic [4:0]       q_addr [2][DEPTH];
  logic [31:0]      q_data [2][DEPTH];
  logic [AW-1:0]    wr_ptr [2];
  logic [AW-1:0]    rd_ptr [2];
  logic [AW:0]      count  [2];
  logic [DEPTH-1:0] slot_valid [2];
  logic [4:0]       req_addr [2];
  logic [31:0]      req_data [2];
  logic [1:0]       req_valid, ready, push, pop, nonempty, full, conflict;
  logic             last_b;
  logic             src;

  always_comb begin
    req_valid   = {b_valid, a_valid};
    req_addr[0] = a_addr;
    req_addr[1] = b_addr;
    req_data[0] = a_data;
    req_data[1] = b_data;
  end

  always_comb begin
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_valid[q][i] = ({1'b0, AW'(i) - rd_ptr[q]} < count[q]);
      end
    end
  end

  // Conflict looks only at the other requester; same-requester writes keep FIFO order.
  always_comb begin
    for (int q = 0; q < 2; q++) begin
      conflict[q] = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[1-q][i] && q_addr[1-q][i] == req_addr[q]) conflict[q] = 1'b1;
      end
      if (regWrite && (src == (q == 0)) && writeReg == req_addr[q]) conflict[q] = 1'b1;
      full[q]     = (count[q] == (AW+1)'(DEPTH));
      nonempty[q] = (count[q] != '0);
      ready[q]    = (req_addr[q] == 5'd0) || (!full[q] && !conflict[q]);
      push[q]     = req_valid[q] && ready[q] && (req_addr[q] != 5'd0);
    end
    pop[0] = nonempty[0] && (!nonempty[1] || last_b);
    pop[1] = nonempty[1] && !pop[0];
  end

  assign a_ready = ready[0];
  assign b_ready = ready[1];

  always_comb begin
    pending = '0;
    for (int q = 0; q < 2; q++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_valid[q][i]) pending[q_addr[q][i]] = 1'b1;
      end
    end
    if (regWrite) pending[writeReg] = 1'b1;
    pending[0] = 1'b0;
  end

  assign stall = pending[readReg1] | pending[readReg2];
  assign idle  = !nonempty[0] && !nonempty[1] && !regWrite;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int q = 0; q < 2; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        count[q]  <= '0;
      end
      last_b    <= 1'b1;
      src       <= 1'b0;
      regWrite  <= 1'b0;
      writeReg  <= 5'd0;
      writeData <= 32'd0;
    end else begin
      for (int q = 0; q < 2; q++) begin
        if (push[q]) begin
          q_addr[q][wr_ptr[q]] <= req_addr[q];
          q_data[q][wr_ptr[q]] <= req_data[q];
          wr_ptr[q]            <= wr_ptr[q] + AW'(1);
        end
        if (pop[q]) rd_ptr[q] <= rd_ptr[q] + AW'(1);
        count[q] <= count[q] + (AW+1)'(push[q]) - (AW+1)'(pop[q]);
      end
      regWrite <= |pop;
      if (|pop) begin
        src       <= pop[1];
        last_b    <= pop[1];
        writeReg  <= pop[1] ? q_addr[1][rd_ptr[1]] : q_addr[0][rd_ptr[0]];
        writeData <= pop[1] ? q_data[1][rd_ptr[1]] : q_data[0][rd_ptr[0]];
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb/tb_regfile_wb_sched.sv - self-checking bench for regfile_wb_sched against a queue-based model
module tb_regfile_wb_sched;
  localparam int DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        regWrite;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  readReg1 = '0, readReg2 = '0;
  logic        stall;
  logic [31:0] pending;
  logic        idle;

  regfile_wb_sched #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .readReg1(readReg1), .readReg2(readReg2),
    .stall(stall), .pending(pending), .idle(idle)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Reference: per-requester queues of {addr,data}, the write in flight, and the last winner.
  logic [36:0] qa[$];
  logic [36:0] qb[$];
  logic        out_v, out_src, last_b;
  logic [4:0]  out_reg;
  logic [31:0] out_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    qa.delete();
    qb.delete();
    out_v = 1'b0; out_src = 1'b0; last_b = 1'b1;
    out_reg = '0; out_data = '0;
  endtask

  function automatic bit has_addr(input bit which, input logic [4:0] a);
    if (!which) begin
      foreach (qa[i]) if (qa[i][36:32] == a) return 1'b1;
    end else begin
      foreach (qb[i]) if (qb[i][36:32] == a) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_ready(input bit x, input logic [4:0] a);
    int sz;
    if (a == 5'd0) return 1'b1;
    sz = x ? qb.size() : qa.size();
    if (sz >= DEPTH) return 1'b0;
    if (has_addr(!x, a)) return 1'b0;
    if (out_v && out_src == !x && out_reg == a) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_pending();
    logic [31:0] p = '0;
    foreach (qa[i]) p[qa[i][36:32]] = 1'b1;
    foreach (qb[i]) p[qb[i][36:32]] = 1'b1;
    if (out_v) p[out_reg] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_all();
    logic [31:0] p;
    p = exp_pending();
    check("a_ready", a_ready, exp_ready(1'b0, a_addr));
    check("b_ready", b_ready, exp_ready(1'b1, b_addr));
    check("pending", pending, p);
    check("stall", stall, p[readReg1] | p[readReg2]);
    check("idle", idle, qa.size() == 0 && qb.size() == 0 && !out_v);
    check("regWrite", regWrite, out_v);
    check("writeReg", writeReg, out_reg);
    check("writeData", writeData, out_data);
  endtask

  task automatic model_edge();
    bit ra, rb;
    logic [36:0] e;
    if (reset) begin
      model_clear();
      return;
    end
    ra = exp_ready(1'b0, a_addr);
    rb = exp_ready(1'b1, b_addr);
    out_v = 1'b0;
    if (qa.size() > 0 && (qb.size() == 0 || last_b)) begin
      e = qa.pop_front();
      out_v = 1'b1; out_src = 1'b0; last_b = 1'b0;
      out_reg = e[36:32]; out_data = e[31:0];
    end else if (qb.size() > 0) begin
      e = qb.pop_front();
      out_v = 1'b1; out_src = 1'b1; last_b = 1'b1;
      out_reg = e[36:32]; out_data = e[31:0];
    end
    if (a_valid && ra && a_addr != 5'd0) qa.push_back({a_addr, a_data});
    if (b_valid && rb && b_addr != 5'd0) qb.push_back({b_addr, b_data});
  endtask

  // Check pre-edge outputs on the falling edge, advance the model, return 1 time unit past the edge.
  task automatic cycle();
    @(negedge clock);
    check_all();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rr_exp [4];
    bit found;

    model_clear();
    @(posedge clock);
    #1;
    cycle();
    reset = 1'b0;
    check("rst_regWrite", regWrite, 0);
    check("rst_idle", idle, 1);
    check("rst_pending", pending, 0);

    // single write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    cycle();
    a_valid = 1'b0;
    check("t1_pend5", pending[5], 1);
    cycle();
    check("t1_regWrite", regWrite, 1);
    check("t1_writeReg", writeReg, 5);
    check("t1_writeData", writeData, 32'hDEADBEEF);
    cycle();
    check("t1_pend5_clear", pending[5], 0);
    check("t1_idle", idle, 1);

    // round-robin, A wins first after reset
    do_reset();
    rr_exp = '{5'd1, 5'd3, 5'd2, 5'd4};
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
    cycle();
    a_addr = 5'd2; a_data = 32'h22;
    b_addr = 5'd4; b_data = 32'h44;
    cycle();
    a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("rr_regWrite", regWrite, 1);
      check("rr_order", writeReg, rr_exp[k]);
      cycle();
    end
    check("rr_done", regWrite, 0);

    // cross-requester WAW block
    do_reset();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h77;
    cycle();
    b_valid = 1'b0;
    a_addr = 5'd7; #1;
    check("waw_block_q", a_ready, 0);
    a_addr = 5'd8; #1;
    check("waw_other_ok", a_ready, 1);
    a_addr = 5'd7;
    cycle();
    check("waw_block_out", a_ready, 0);
    cycle();
    check("waw_release", a_ready, 1);
    a_valid = 1'b1; a_data = 32'h70;
    cycle();
    a_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle();

    // $zero write is swallowed
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h1234; #1;
    check("zero_ready", a_ready, 1);
    cycle();
    a_valid = 1'b0;
    check("zero_pending", pending, 0);
    check("zero_idle", idle, 1);
    cycle();
    check("zero_noissue", regWrite, 0);

    // fill A while B competes for the port
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      a_valid = 1'b1; a_addr = 5'(10 + k); a_data = $urandom;
      b_valid = 1'b1; b_addr = 5'(20 + k); b_data = $urandom;
      cycle();
      if (qa.size() == DEPTH) found = 1'b1;
    end
    a_valid = 1'b0; b_valid = 1'b0; #1;
    if (!found) begin
      checks++; fails++;
      $error("FAIL full_reached observed=0 expected=1");
    end else begin
      check("full_ready", a_ready, 0);
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
        cycle();
        if (qa.size() < DEPTH) begin
          check("full_release", a_ready, 1);
          found = 1'b1;
        end
      end
      if (!found) begin
        checks++; fails++;
        $error("FAIL full_release_timeout observed=0 expected=1");
      end
    end
    for (int k = 0; k < 6; k++) cycle();

    // decode stall
    do_reset();
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    readReg1 = 5'd9; readReg2 = 5'd0;
    cycle();
    b_valid = 1'b0;
    check("stall_queued", stall, 1);
    readReg1 = 5'd0; #1;
    check("stall_zero", stall, 0);
    readReg1 = 5'd9;
    cycle();
    check("stall_out", stall, 1);
    cycle();
    check("stall_clear", stall, 0);
    readReg1 = 5'd0;

    // reset while a write is in the output stage
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD;
    cycle();
    a_addr = 5'd14; a_data = 32'hE;
    b_valid = 1'b0;
    cycle();
    a_valid = 1'b0;
    check("mid_regWrite_hi", regWrite, 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mid_regWrite", regWrite, 0);
    check("mid_pending", pending, 0);
    check("mid_idle", idle, 1);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("mid_noissue", regWrite, 0);
    end

    // randomized traffic with narrow address range to provoke conflicts
    for (int n = 0; n < 500; n++) begin
      a_valid  = 1'($urandom_range(0, 1));
      b_valid  = 1'($urandom_range(0, 1));
      a_addr   = 5'($urandom_range(0, 15));
      b_addr   = 5'($urandom_range(0, 15));
      a_data   = $urandom;
      b_data   = $urandom;
      readReg1 = 5'($urandom_range(0, 15));
      readReg2 = 5'($urandom_range(0, 15));
      reset    = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    for (int k = 0; k < 8; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
